// File: rtl/vga_scanout.sv
// Pixel scanout stage: prefetches framebuffer words into a small FIFO and
// drives RGB to the DAC, aligned with one-cycle-delayed timing signals.
module vga_scanout #(
  parameter int HRES       = 800,
  parameter int VRES       = 600,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        vga_red,
  output logic [7:0]        vga_grn,
  output logic [7:0]        vga_blue,
  output logic              vga_blank_n,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start,
  output logic              underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(HRES*VRES-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state, state_next;

  logic              vsync_q;
  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetched;
  logic              accept, push, pop, fifo_empty;

  // mem_req/mem_ack form a single-outstanding handshake: a word transfers in
  // any cycle where both are high, and mem_addr only moves after a transfer.
  assign mem_addr   = fetch_addr;
  assign accept     = mem_req & mem_ack;
  assign fifo_empty = (count == '0);
  assign push       = (state == FETCH) & accept & ~frame_start;
  assign pop        = blank_n & ~fifo_empty & ~frame_start;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      frame_start <= vsync_q & ~vsync;
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_next = FETCH;
      end
      FETCH: begin
        mem_req = (count != FULL_COUNT);
        // A request left hanging at frame start must still complete at its old address.
        if (frame_start)
          state_next = (mem_req && !mem_ack) ? FLUSH : FETCH;
        else if (accept && fetched == LAST_WORD)
          state_next = DONE;
      end
      DONE: begin
        if (frame_start) state_next = FETCH;
      end
      FLUSH: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      fetch_addr <= '0;
      fetched    <= '0;
    end else if (frame_start) begin
      fetched <= '0;
      if (state_next != FLUSH) fetch_addr <= '0;
    end else if (state == FLUSH && mem_ack) begin
      fetch_addr <= '0;
    end else if (push) begin
      fetch_addr <= fetch_addr + 1'b1;
      fetched    <= fetched + 1'b1;
    end
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      vga_red     <= '0;
      vga_grn     <= '0;
      vga_blue    <= '0;
      vga_blank_n <= 1'b0;
      vga_hsync   <= 1'b0;
      vga_vsync   <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vga_blank_n <= blank_n;
      vga_hsync   <= hsync;
      vga_vsync   <= vsync;
      if (pop) {vga_red, vga_grn, vga_blue} <= fifo_mem[rd_ptr];
      else     {vga_red, vga_grn, vga_blue} <= 24'd0;
      // Lost pixels are not replayed; the flag just records that it happened.
      if (frame_start)               underflow <= 1'b0;
      else if (blank_n & fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Pixel scanout stage sitting directly downstream of the VGA timing controller. Consumes its hsync/vsync/blank timing. Prefetches framebuffer pixels over a simple req/ack memory port into a small FIFO. Drives RGB to the video DAC, aligned with delayed copies of the timing signals.

Parameters:
HRES, 800, active pixels per line.
VRES, 600, active lines per frame.
ADDR_W, 20, framebuffer word address width; must satisfy 2^ADDR_W >= HRES*VRES.
FIFO_DEPTH, 16, pixel FIFO depth; power of 2, >= 4.

Ports:
pixel_clock  in  1  pixel clock, rising edge.
reset  in  1  asynchronous, active-high reset.
hsync  in  1  from timing controller, active low.
vsync  in  1  from timing controller, active low.
blank_n  in  1  from timing controller; 1 = active video pixel this cycle.
mem_req  out  1  read request to framebuffer.
mem_addr  out  ADDR_W  word address; stable while mem_req high.
mem_ack  in  1  request accepted; mem_rdata valid in the same cycle.
mem_rdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
vga_red  out  8  DAC red.
vga_grn  out  8  DAC green.
vga_blue  out  8  DAC blue.
vga_blank_n  out  1  blank_n delayed 1 cycle.
vga_hsync  out  1  hsync delayed 1 cycle.
vga_vsync  out  1  vsync delayed 1 cycle.
frame_start  out  1  one-cycle pulse on vsync falling edge.
underflow  out  1  sticky flag: FIFO was empty during active video this frame.

Behaviour:
- Reset (async, any time): every output = 0.
  - FIFO pointers and count = 0; fetch address = 0; fetched count = 0.
  - Fetch FSM = IDLE; vsync edge register = 1.
  - Reset mid-request drops the request with no ack required.
- Frame start:
  - vsync_q registered each cycle.
  - frame_start = vsync_q & ~vsync, registered, asserted one cycle later.
  - While frame_start is high: FIFO flushed (pointers/count = 0); fetch address = 0; fetched count = 0; underflow cleared; FSM -> FETCH (or FLUSH, see below).
- Fetch FSM:
  - IDLE: mem_req = 0. Waits for frame_start.
  - FETCH: mem_req = 1 while fifo_count < FIFO_DEPTH and fetched < HRES*VRES. mem_addr = fetch address.
    - On mem_ack: mem_rdata pushed into FIFO that cycle; address += 1; fetched += 1.
    - Single outstanding request. Back-to-back acks allowed, one per cycle.
    - mem_req drops the cycle after the ack that fills the FIFO or completes the frame.
    - fetched == HRES*VRES -> DONE.
  - DONE: mem_req = 0. frame_start -> FETCH.
  - FLUSH: entered when frame_start arrives while mem_req = 1 and no ack that cycle.
    - mem_req held high with the old mem_addr until mem_ack.
    - Acked data is discarded, not pushed.
    - Then -> FETCH at address 0.
    - Rule: mem_addr never changes while mem_req = 1 and mem_ack = 0.
- Output pipeline, latency 1 cycle from the timing inputs:
  - vga_hsync/vga_vsync/vga_blank_n <= hsync/vsync/blank_n.
  - If blank_n = 1 and FIFO non-empty: pop; RGB <= head word.
  - If blank_n = 1 and FIFO empty: RGB <= 0 and underflow <= 1. Nothing popped; pixel lost, no re-sync within the frame.
  - If blank_n = 0: RGB <= 0, no pop.
- FIFO:
  - Push and pop in the same cycle leaves the count unchanged; allowed when full (pop frees the slot) and when empty (push then pop next cycle, no bypass).
  - Push never occurs when count == FIFO_DEPTH, guaranteed by the req gating.
  - Pointers wrap modulo FIFO_DEPTH.
- Widths:
  - fetched counter is ADDR_W bits and compares against the constant HRES*VRES.
  - Address wrap beyond HRES*VRES-1 cannot occur, since DONE stops fetching.
- Simultaneous frame_start and pop: flush wins; no pop takes effect.

Test Plan:
- Reset with HRES=4, VRES=2, FIFO_DEPTH=4: assert reset mid-frame -> all outputs 0 the same cycle; mem_req=0 until the next vsync falling edge.
- Fill: vsync fall, mem_ack always 1, rdata=addr, blank_n=0 -> frame_start pulse; acks at addrs 0..3; mem_req low after the 4th ack; FIFO full.
- Scanout order: then blank_n=1 for 4 cycles -> RGB = 0x000000, 0x000001, 0x000002, 0x000003, each one cycle after its blank_n; vga_blank_n matches blank_n delayed 1; refills from addr 4.
- Underflow: mem_ack tied 0, blank_n=1 for 2 cycles -> RGB=0 and underflow=1, held until the next frame_start, then 0.
- Frame end: after 8 acks -> DONE, mem_req stays 0 through further active cycles. Next vsync fall -> mem_addr=0.
- Flush: vsync fall while mem_req=1 at addr 5 with ack withheld 3 cycles -> mem_addr stays 5; acked data not output; next request addr 0.
